// File: rtl/regfile_shadowed.sv
// Shadowed configuration register file: interface writes land in a shadow bank,
// and a commit strobe copies every shadow word into the active bank on one edge.
module regfile_shadowed #(
  parameter int NUMREGS    = 16,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int ERR_WIDTH  = 4,
  parameter logic [NUMREGS*DATA_WIDTH-1:0] RESET_VALUES = '0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [DATA_WIDTH-1:0] config_bits [0:NUMREGS-1],
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  read,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  input  logic                  read_shadow,
  output logic [DATA_WIDTH-1:0] read_data,
  output logic                  read_valid,
  input  logic                  commit,
  input  logic                  lock,
  output logic                  pending,
  output logic                  addr_err,
  output logic [ERR_WIDTH-1:0]  err_count
);

  // One extra bit so NUMREGS == 2**ADDR_WIDTH is still representable.
  localparam logic [ADDR_WIDTH:0]  NREGS_EXT = (ADDR_WIDTH+1)'(NUMREGS);
  localparam logic [ERR_WIDTH-1:0] ERR_MAX   = '1;

  logic [DATA_WIDTH-1:0] shadow_q [0:NUMREGS-1];
  logic [DATA_WIDTH-1:0] shadow_d [0:NUMREGS-1];
  logic [DATA_WIDTH-1:0] active_q [0:NUMREGS-1];
  logic [DATA_WIDTH-1:0] active_d [0:NUMREGS-1];
  logic                  pending_q, pending_d;
  logic [DATA_WIDTH-1:0] read_data_q, read_data_d;
  logic                  read_valid_q, read_valid_d;
  logic                  addr_err_q, addr_err_d;
  logic [ERR_WIDTH-1:0]  err_count_q, err_count_d;

  logic                  wr_in_range, rd_in_range, wr_ok, err_evt;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    wr_in_range = ({1'b0, write_addr} < NREGS_EXT);
    rd_in_range = ({1'b0, read_addr} < NREGS_EXT);
    wr_ok       = write & wr_in_range & ~lock;
    err_evt     = (write & ~(wr_in_range & ~lock)) | (read & ~rd_in_range);

    shadow_d = shadow_q;
    if (commit) active_d = shadow_q;
    else        active_d = active_q;

    // Reads see the bank contents from before this edge's write/commit.
    rd_word = '0;
    for (int i = 0; i < NUMREGS; i++) begin
      if (wr_ok && (write_addr == ADDR_WIDTH'(i))) shadow_d[i] = write_data;
      if (rd_in_range && (read_addr == ADDR_WIDTH'(i)))
        rd_word = read_shadow ? shadow_q[i] : active_q[i];
    end

    // A write in the same cycle as a commit leaves new uncommitted data behind.
    if (wr_ok)       pending_d = 1'b1;
    else if (commit) pending_d = 1'b0;
    else             pending_d = pending_q;

    read_valid_d = read;
    read_data_d  = read ? rd_word : read_data_q;
    addr_err_d   = err_evt;
    err_count_d  = (err_evt && (err_count_q != ERR_MAX)) ? err_count_q + 1'b1 : err_count_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUMREGS; i++) begin
        shadow_q[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
        active_q[i] <= RESET_VALUES[i*DATA_WIDTH +: DATA_WIDTH];
      end
      pending_q    <= 1'b0;
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
      addr_err_q   <= 1'b0;
      err_count_q  <= '0;
    end else begin
      shadow_q     <= shadow_d;
      active_q     <= active_d;
      pending_q    <= pending_d;
      read_data_q  <= read_data_d;
      read_valid_q <= read_valid_d;
      addr_err_q   <= addr_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign config_bits = active_q;
  assign read_data   = read_data_q;
  assign read_valid  = read_valid_q;
  assign pending     = pending_q;
  assign addr_err    = addr_err_q;
  assign err_count   = err_count_q;

endmodule
